// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dual-port RAM round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpram_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 8;
    localparam int IDX_W    = $clog2(NREQ_MAX);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rsp_pend_t;

    // Increment with wrap at n; used for both the rotating pointer and the port B scan start.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/dpram_arbiter_if.sv
// Requester, response and RAM-port bundle between the requesters, the arbiter and the RAM.
// Latency: n/a (wiring only).
// Backpressure: req_ready is the per-requester grant; responses cannot be stalled.
interface dpram_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;

    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_rdata;

    logic               ram_we_a;
    logic               ram_we_b;
    logic [AW-1:0]      ram_addr_a;
    logic [AW-1:0]      ram_addr_b;
    logic [DW-1:0]      ram_din_a;
    logic [DW-1:0]      ram_din_b;
    logic [DW-1:0]      ram_dout_a;
    logic [DW-1:0]      ram_dout_b;

    // Environment side: requesters plus the RAM's read data.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_dout_a, ram_dout_b,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_dout_a, ram_dout_b,
        output req_ready, rsp_valid, rsp_rdata,
        output ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b
    );

endinterface

// File: rtl/dpram_arbiter_rr_pick.sv
// rr_pick: find-first-set over req starting at index start, wrapping past N-1 to 0.
// Latency: combinational.
// Backpressure: none.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(start) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the A/B ports of a dual-port RAM.
// Latency: grant is combinational (0 cycles); read data returns on rsp_valid exactly 1 cycle after grant.
// Backpressure: req_ready is the grant; responses are unconditional. DPRAM_ARB_STATS_EN adds grant counters.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    dpram_arbiter_if.slave bus
`ifdef DPRAM_ARB_STATS_EN
    ,
    input  logic [2:0]     stat_sel,
    output logic [15:0]    stat_count
`endif
);

    localparam int IW = $clog2(NREQ);

    logic            a_found;
    logic            b_found;
    logic [IW-1:0]   a_idx;
    logic [IW-1:0]   b_idx;
    logic [IW-1:0]   b_start;
    logic [NREQ-1:0] b_req;

    logic            a_we;
    logic            b_we;
    logic [AW-1:0]   a_addr;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   a_wdata;
    logic [DW-1:0]   b_wdata;

    logic            conflict;
    logic            a_gnt;
    logic            b_gnt;
    logic [NREQ-1:0] ready;

    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   rr_ptr_d;
    rsp_pend_t       pend_a_q;
    rsp_pend_t       pend_a_d;
    rsp_pend_t       pend_b_q;
    rsp_pend_t       pend_b_d;

    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_rdata;
    logic               hit_a;
    logic               hit_b;
    port_sel_t          src;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
        .req   (bus.req_valid),
        .start (rr_ptr_q),
        .found (a_found),
        .idx   (a_idx)
    );

    // Port B continues the same scan just past the port A winner.
    always_comb begin
        b_start        = IW'(wrap_inc(32'(a_idx), NREQ));
        b_req          = bus.req_valid;
        b_req[a_idx]   = 1'b0;
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
        .req   (b_req),
        .start (b_start),
        .found (b_found),
        .idx   (b_idx)
    );

    always_comb begin
        a_we     = bus.req_we[a_idx];
        b_we     = bus.req_we[b_idx];
        a_addr   = bus.req_addr[int'(a_idx)*AW +: AW];
        b_addr   = bus.req_addr[int'(b_idx)*AW +: AW];
        a_wdata  = bus.req_wdata[int'(a_idx)*DW +: DW];
        b_wdata  = bus.req_wdata[int'(b_idx)*DW +: DW];

        // Same-address pairs involving a write would race inside the RAM; B yields.
        conflict = (a_addr == b_addr) && (a_we || b_we);
        a_gnt    = reset_n && a_found;
        b_gnt    = reset_n && a_found && b_found && !conflict;

        ready = '0;
        if (a_gnt) ready[a_idx] = 1'b1;
        if (b_gnt) ready[b_idx] = 1'b1;
    end

    assign bus.req_ready  = ready;
    assign bus.ram_we_a   = a_gnt & a_we;
    assign bus.ram_we_b   = b_gnt & b_we;
    assign bus.ram_addr_a = a_gnt ? a_addr  : '0;
    assign bus.ram_addr_b = b_gnt ? b_addr  : '0;
    assign bus.ram_din_a  = a_gnt ? a_wdata : '0;
    assign bus.ram_din_b  = b_gnt ? b_wdata : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (b_gnt) begin
            rr_ptr_d = IW'(wrap_inc(32'(b_idx), NREQ));
        end else if (a_gnt) begin
            rr_ptr_d = IW'(wrap_inc(32'(a_idx), NREQ));
        end

        pend_a_d.valid = a_gnt && !a_we;
        pend_a_d.idx   = IDX_W'(a_idx);
        pend_b_d.valid = b_gnt && !b_we;
        pend_b_d.idx   = IDX_W'(b_idx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            pend_a_q <= '0;
            pend_b_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
        end
    end

    // The RAM's registered dout lines up with the pending record captured at the grant edge.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        hit_a     = 1'b0;
        hit_b     = 1'b0;
        src       = PORT_A;
        for (int i = 0; i < NREQ; i++) begin
            hit_a = pend_a_q.valid && (pend_a_q.idx == IDX_W'(i));
            hit_b = pend_b_q.valid && (pend_b_q.idx == IDX_W'(i));
            if (hit_a || hit_b) begin
                src                   = hit_a ? PORT_A : PORT_B;
                rsp_valid[i]          = 1'b1;
                rsp_rdata[i*DW +: DW] = (src == PORT_A) ? bus.ram_dout_a : bus.ram_dout_b;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;

`ifdef DPRAM_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] cnt_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.req_valid[i] && ready[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stat_sel == 3'(i)) stat_count = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: list-based arbitration model with shadow memory checked every cycle, plus directed literal checks.
// Define DPRAM_ARB_STATS_EN to also exercise the saturating grant counters.
module tb_dpram_arbiter;
    import dpram_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam logic [7:0] MEM_INIT [16] = '{
        8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h3C, 8'h66, 8'h77,
        8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF
    };

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    dpram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

`ifdef DPRAM_ARB_STATS_EN
    logic [2:0]  stat_sel = 3'd0;
    logic [15:0] stat_count;
`endif

    dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus)
`ifdef DPRAM_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 dual-port RAM with registered read.
    logic [7:0] ram_mem [16] = MEM_INIT;
    always @(posedge clk) begin
        if (bus.ram_we_a) ram_mem[bus.ram_addr_a] <= bus.ram_din_a;
        if (bus.ram_we_b) ram_mem[bus.ram_addr_b] <= bus.ram_din_b;
        bus.ram_dout_a <= ram_mem[bus.ram_addr_a];
        bus.ram_dout_b <= ram_mem[bus.ram_addr_b];
    end

    // Reference model state.
    int         m_ptr = 0;
    logic [7:0] m_mem [16] = MEM_INIT;
    bit         m_pv  [NREQ];
    logic [7:0] m_pd  [NREQ];
    int         m_cnt [NREQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] f_addr(input int i);
        return bus.req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] f_wdata(input int i);
        return bus.req_wdata[i*DW +: DW];
    endfunction

    task automatic monitor();
        int              cand[$];
        int              ga;
        int              gb;
        int              last;
        logic [NREQ-1:0]    exp_rv;
        logic [NREQ-1:0]    exp_rdy;
        logic [NREQ*DW-1:0] exp_rd;
        logic [AW+DW:0]     exp_pa;
        logic [AW+DW:0]     exp_pb;
        exp_rv  = '0;
        exp_rdy = '0;
        exp_rd  = '0;
        exp_pa  = '0;
        exp_pb  = '0;
        if (!reset_n) begin
            m_ptr = 0;
            for (int i = 0; i < NREQ; i++) begin
                m_pv[i]  = 1'b0;
                m_cnt[i] = 0;
            end
            chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.ram_we_a, bus.ram_we_b}, '0);
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_pv[i]) begin
                    exp_rv[i]          = 1'b1;
                    exp_rd[i*DW +: DW] = m_pd[i];
                end
            end
            chk("rsp_valid", bus.rsp_valid, exp_rv);
            chk("rsp_rdata", bus.rsp_rdata, exp_rd);

            for (int k = 0; k < NREQ; k++) begin
                if (bus.req_valid[(m_ptr + k) % NREQ]) cand.push_back((m_ptr + k) % NREQ);
            end
            ga = (cand.size() > 0) ? cand[0] : -1;
            gb = (cand.size() > 1) ? cand[1] : -1;
            if (gb >= 0 && f_addr(ga) == f_addr(gb) && (bus.req_we[ga] || bus.req_we[gb])) gb = -1;

            if (ga >= 0) begin
                exp_rdy[ga] = 1'b1;
                exp_pa      = {bus.req_we[ga], f_addr(ga), f_wdata(ga)};
            end
            if (gb >= 0) begin
                exp_rdy[gb] = 1'b1;
                exp_pb      = {bus.req_we[gb], f_addr(gb), f_wdata(gb)};
            end
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("ram_port_a", {bus.ram_we_a, bus.ram_addr_a, bus.ram_din_a}, exp_pa);
            chk("ram_port_b", {bus.ram_we_b, bus.ram_addr_b, bus.ram_din_b}, exp_pb);
`ifdef DPRAM_ARB_STATS_EN
            chk("stat_count", stat_count, (int'(stat_sel) < NREQ) ? 16'(m_cnt[stat_sel]) : 16'h0);
`endif

            // Commit: reads see memory before this edge's writes.
            for (int i = 0; i < NREQ; i++) m_pv[i] = 1'b0;
            if (ga >= 0 && !bus.req_we[ga]) begin m_pv[ga] = 1'b1; m_pd[ga] = m_mem[f_addr(ga)]; end
            if (gb >= 0 && !bus.req_we[gb]) begin m_pv[gb] = 1'b1; m_pd[gb] = m_mem[f_addr(gb)]; end
            if (ga >= 0 && bus.req_we[ga]) m_mem[f_addr(ga)] = f_wdata(ga);
            if (gb >= 0 && bus.req_we[gb]) m_mem[f_addr(gb)] = f_wdata(gb);
            if (ga >= 0 && m_cnt[ga] < 65535) m_cnt[ga]++;
            if (gb >= 0 && m_cnt[gb] < 65535) m_cnt[gb]++;
            last = (gb >= 0) ? gb : ga;
            if (last >= 0) m_ptr = (last + 1) % NREQ;
        end
    endtask

    // Check at the falling edge, then move to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset: requests present but nothing may be granted.
        bus.req_valid = 4'b1111;
        #2;
        chk("reset_ready", bus.req_ready, 4'b0000);
        chk("reset_rsp", bus.rsp_valid, 4'b0000);
        tick();
        tick();
        reset_n       = 1'b1;
        bus.req_valid = '0;
        tick();

        // Single read of addr 5.
        set_req(0, 1'b0, 4'd5, 8'h00);
        bus.req_valid = 4'b0001;
        #1;
        chk("t1_ready", bus.req_ready, 4'b0001);
        chk("t1_addr_a", bus.ram_addr_a, 4'd5);
        tick();
        chk("t1_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t1_rdata", bus.rsp_rdata[7:0], 8'h3C);
        bus.req_valid = '0;
        tick();
        chk("t1_rsp_once", bus.rsp_valid, 4'b0000);

        // Reset right after a read grant discards the response.
        set_req(2, 1'b0, 4'd9, 8'h00);
        bus.req_valid = 4'b0100;
        tick();
        reset_n       = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("rst_drop", bus.rsp_valid, 4'b0000);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_no_rsp", bus.rsp_valid, 4'b0000);

        // All four read; first grant pair (0,1) shows the pointer restarted at 0.
        set_req(0, 1'b0, 4'd1, 8'h00);
        set_req(1, 1'b0, 4'd2, 8'h00);
        set_req(2, 1'b0, 4'd4, 8'h00);
        set_req(3, 1'b0, 4'd6, 8'h00);
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rr_ready%0d", c), bus.req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            tick();
            if (c == 0) begin
                chk("rr_rsp_valid", bus.rsp_valid, 4'b0011);
                chk("rr_rdata", bus.rsp_rdata, 32'h0000_2211);
            end
        end

        // Two writes to addr 7: B yields, then wins next cycle.
        set_req(1, 1'b1, 4'd7, 8'hAA);
        set_req(2, 1'b1, 4'd7, 8'h55);
        bus.req_valid = 4'b0110;
        #1;
        chk("ww_first", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        chk("ww_second", bus.req_ready, 4'b0100);
        chk("ww_port_a", {bus.ram_we_a, bus.ram_addr_a, bus.ram_din_a}, {1'b1, 4'd7, 8'h55});
        tick();
        set_req(0, 1'b0, 4'd7, 8'h00);
        bus.req_valid = 4'b0001;
        tick();
        chk("ww_final", bus.rsp_rdata[7:0], 8'h55);

        // Write then read the same address on consecutive cycles.
        set_req(0, 1'b1, 4'd3, 8'h11);
        tick();
        set_req(0, 1'b0, 4'd3, 8'h00);
        tick();
        bus.req_valid = '0;
        chk("wr_rd_valid", bus.rsp_valid, 4'b0001);
        chk("wr_rd_data", bus.rsp_rdata[7:0], 8'h11);
        tick();

        // Two reads of the same address may share the cycle.
        set_req(0, 1'b0, 4'd5, 8'h00);
        set_req(1, 1'b0, 4'd5, 8'h00);
        bus.req_valid = 4'b0011;
        #1;
        chk("rr_same_addr", bus.req_ready, 4'b0011);
        tick();
        bus.req_valid = '0;
        chk("rr_same_data", bus.rsp_rdata, 32'h0000_3C3C);

        // Write and read of one address collide; the read waits a cycle.
        set_req(2, 1'b1, 4'd4, 8'h5A);
        set_req(3, 1'b0, 4'd4, 8'h00);
        bus.req_valid = 4'b1100;
        #1;
        chk("wr_conflict", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b1000;
        #1;
        chk("wr_conflict_next", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        chk("wr_conflict_data", bus.rsp_rdata[31:24], 8'h5A);
        tick();

`ifdef DPRAM_ARB_STATS_EN
        set_req(3, 1'b0, 4'd1, 8'h00);
        bus.req_valid = 4'b1000;
        stat_sel      = 3'd3;
        for (int n = 0; n < 70000; n++) tick();
        bus.req_valid = '0;
        #1;
        chk("stat_saturate", stat_count, 16'hFFFF);
        stat_sel = 3'd6;
        #1;
        chk("stat_out_of_range", stat_count, 16'h0000);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Round-robin arbiter that shares the team's 16x8 dual-port RAM between NREQ independent requesters. Each cycle it grants up to two requests, one per RAM port (A and B), drives the RAM port signals, and returns read data to the issuing requester one cycle later. It sits between the requester blocks and the RAM, and is the only driver of the RAM's port signals.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 4, RAM address width
- DW, 8, RAM data width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  address, requester i at bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  grant; transfer occurs when req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  read data valid for requester i
- rsp_rdata  out  NREQ*DW  read data, requester i at bits [i*DW +: DW]
- ram_we_a / ram_we_b  out  1  RAM write enables
- ram_addr_a / ram_addr_b  out  AW  RAM addresses
- ram_din_a / ram_din_b  out  DW  RAM write data
- ram_dout_a / ram_dout_b  in  DW  RAM registered read data
- stat_sel  in  3  requester select for grant counter (DPRAM_ARB_STATS_EN only)
- stat_count  out  16  grant count of requester stat_sel (DPRAM_ARB_STATS_EN only)

## Operation
- State: rr_ptr (log2 NREQ bits), rsp_pend_a/b (valid + requester index), optional counters.
- Arbitration is combinational within the cycle.
  - Port A: first requester with req_valid set, scanning from rr_ptr upward with wrap.
  - Port B: next valid requester after the port A winner, in the same scan order.
- Conflict rule: if the A and B winners have equal addresses and at least one is a write, B is not granted that cycle. Its requester stays valid and competes again next cycle.
- req_ready[i] = 1 only for granted requesters. Requesters hold valid/we/addr/wdata stable until ready; dropping valid before ready is allowed.
- Port mapping: ram_we_x = granted & we; ram_addr_x / ram_din_x = granted requester's fields.
  - Idle port: we = 0, addr = 0, din = 0.
- A granted read sets rsp_pend_x. A granted write produces no response.
- rr_ptr update after any grant: (index of the last granted requester + 1) mod NREQ. No grant: unchanged.
- Response routing:
  - rsp_valid[i] = 1 when rsp_pend_a or rsp_pend_b names requester i.
  - rsp_rdata slice i = ram_dout_a or ram_dout_b, whichever port carried that requester's read.
  - Non-responding slices are 0.
- Reset values: rr_ptr = 0, rsp_pend cleared, rsp_valid = 0, rsp_rdata = 0, counters = 0. req_ready = 0 and ram_we_* = 0 while reset_n is low.

## Timing
- Grant latency: 0 cycles. req_ready is asserted in the same cycle as req_valid when the requester wins.
- Read latency: 1 cycle. A read granted in cycle t has rsp_valid asserted for exactly cycle t+1.
- Throughput: 2 transfers per cycle maximum; a single requester gets at most 1 grant per cycle.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.
- Write then read of the same address in consecutive cycles returns the new data (RAM write lands at edge t).
- Reset asserted mid-operation: pending responses are discarded immediately (asynchronous); no rsp_valid after release.
- After reset_n deasserts, the first edge may grant.

## Configuration
- DPRAM_ARB_STATS_EN defined:
  - One 16-bit saturating grant counter per requester, incremented on every transfer (read or write). Holds at 0xFFFF.
  - stat_count = counter[stat_sel], combinational. stat_sel >= NREQ reads 0.
- Undefined: counters, stat_sel and stat_count are absent. Arbitration behaviour is identical.

## Structure
- Package dpram_arb_pkg:
  - constants NREQ_MAX = 8, AW_DEF = 4, DW_DEF = 8
  - typedef port_sel_t {PORT_A, PORT_B}
  - typedef rsp_pend_t {valid, idx}
- Sub-module rr_pick: find-first-set from a start index with wrap, returns found + index.
  - Instantiated twice: the second instance has the port A winner masked out and starts from the A winner + 1.

## Test plan
- Requester 0 reads addr 5 alone, RAM holds 0x3C at 5 -> ready[0] in cycle t; rsp_valid[0] = 1 with rdata 0x3C in t+1 only.
- All 4 requesters valid with reads at distinct addresses for 4 cycles -> grants (0,1), (2,3), (0,1), (2,3); rr_ptr returns to 0.
- Req 1 writes 0xAA to addr 7 while req 2 writes 0x55 to addr 7 -> only req 1 granted; req 2 granted next cycle; final mem[7] = 0x55.
- Req 0 writes 0x11 to addr 3 in cycle t, req 0 reads addr 3 in cycle t+1 -> rsp_rdata 0x11 in t+2.
- reset_n pulled low in the cycle after a read grant -> rsp_valid never asserts; rr_ptr = 0 after release.
- With DPRAM_ARB_STATS_EN, requester 3 gets 70000 transfers -> stat_count saturates at 0xFFFF with stat_sel = 3.
